// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump engine.
// Holds the FSM state encoding and the default entry/index widths.
// No logic; imported by regfile_dump.
package regfile_dump_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_dump.sv
// Purpose: streams register-file entries first_reg..last_reg (inclusive, wrapping) as (addr, data) beats.
// Latency: start accepted at edge N -> dump_valid in cycle N+2; one beat every 2 cycles at full rate.
// Backpressure: waits in SEND with addr/data/last frozen for as long as dump_ready stays low.
// Ports: clk/reset (sync, active-high); start/first_reg/last_reg request a dump (sampled only in IDLE);
//        rf_raddr/rf_rdata form the asynchronous register-file read port;
//        dump_valid/dump_ready/dump_addr/dump_data/dump_last carry beats; busy = not IDLE; done = 1-cycle pulse.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_reg,
  input  logic [ADDR_WIDTH-1:0] last_reg,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_last,
  output logic                  busy,
  output logic                  done
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur;
  logic [ADDR_WIDTH-1:0] end_idx;

  // The read port always points at the current index; only READ captures it.
  assign rf_raddr = cur;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    dump_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = READ;
      end
      READ: state_nxt = SEND;
      SEND: begin
        dump_valid = 1'b1;
        if (dump_ready) state_nxt = dump_last ? DONE : READ;
      end
      DONE: begin
        // start is deliberately not looked at here; a new request needs IDLE.
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= '0;
      end_idx   <= '0;
      dump_addr <= '0;
      dump_data <= '0;
      dump_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur     <= first_reg;
            end_idx <= last_reg;
          end
        end
        READ: begin
          dump_data <= rf_rdata;
          dump_addr <= cur;
          dump_last <= (cur == end_idx);
        end
        SEND: begin
          // Index wraps naturally at 2**ADDR_WIDTH, giving the first>last wrap-around range.
          if (dump_ready && !dump_last) cur <= cur + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: models the register file as an array and checks beats against hand values.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  assign rf_rdata = rf[rf_raddr];

  int vectors = 0;
  int miscompares = 0;

  logic [4:0]  got_addr [40];
  logic [31:0] got_data [40];
  logic        got_last [40];
  int          nbeats, ndone, lat;

  always #5 clk = ~clk;

  regfile_dump dut (
    .clk(clk), .reset(reset), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_last(dump_last), .busy(busy), .done(done)
  );

  // Issues one start and records every beat (ready held high) over a fixed window.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l);
    nbeats = 0; ndone = 0; lat = -1;
    @(negedge clk);
    first_reg = f; last_reg = l; start = 1'b1; dump_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 80; c++) begin
      if (dump_valid && lat < 0) lat = c;
      if (dump_valid && nbeats < 40) begin
        got_addr[nbeats] = dump_addr;
        got_data[nbeats] = dump_data;
        got_last[nbeats] = dump_last;
        nbeats++;
      end
      if (done) ndone++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b1; first_reg = 5'd3; last_reg = 5'd3; dump_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({rf_raddr, dump_addr, dump_data, dump_valid, dump_last, busy, done} !== 44'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: raddr=%h addr=%h data=%h valid=%b last=%b busy=%b done=%b, required all 0",
               rf_raddr, dump_addr, dump_data, dump_valid, dump_last, busy, done);
    end
    reset = 1'b0; start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (dump_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_start_ignored: cycle %0d valid=%b busy=%b, required 0 0", c, dump_valid, busy);
      end
    end
  endtask

  task automatic test_alu_dump();
    logic [31:0] exp_data [7];
    exp_data = '{32'h1, 32'h1, 32'h7, 32'hfffffffb, 32'h3, 32'hfffffff2, 32'hfffffff7};
    run_dump(5'd8, 5'd14);
    vectors++;
    if (nbeats !== 7) begin miscompares++; $display("FAIL alu_beats: got %0d, required 7", nbeats); end
    vectors++;
    if (ndone !== 1) begin miscompares++; $display("FAIL alu_done: got %0d pulses, required 1", ndone); end
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL alu_latency: got %0d, required 2", lat); end
    for (int i = 0; i < 7 && i < nbeats; i++) begin
      vectors++;
      if (got_addr[i] !== 5'(8 + i) || got_data[i] !== exp_data[i] || got_last[i] !== (i == 6)) begin
        miscompares++;
        $display("FAIL alu_beat%0d: addr=%0d data=%h last=%b, required addr=%0d data=%h last=%b",
                 i, got_addr[i], got_data[i], got_last[i], 8 + i, exp_data[i], (i == 6));
      end
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL alu_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_single();
    run_dump(5'd10, 5'd10);
    vectors++;
    if (nbeats !== 1 || ndone !== 1) begin
      miscompares++;
      $display("FAIL single_count: beats=%0d done=%0d, required 1 1", nbeats, ndone);
    end
    vectors++;
    if (got_addr[0] !== 5'd10 || got_data[0] !== 32'h7 || got_last[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL single_beat: addr=%0d data=%h last=%b, required 10 7 1", got_addr[0], got_data[0], got_last[0]);
    end
  endtask

  task automatic test_wrap();
    logic [4:0]  ea [4];
    logic [31:0] ed [4];
    ea = '{5'd30, 5'd31, 5'd0, 5'd1};
    ed = '{32'h3030_0030, 32'hdead_beef, 32'h0, 32'h0000_0011};
    run_dump(5'd30, 5'd1);
    vectors++;
    if (nbeats !== 4 || ndone !== 1) begin
      miscompares++;
      $display("FAIL wrap_count: beats=%0d done=%0d, required 4 1", nbeats, ndone);
    end
    for (int i = 0; i < 4 && i < nbeats; i++) begin
      vectors++;
      if (got_addr[i] !== ea[i] || got_data[i] !== ed[i] || got_last[i] !== (i == 3)) begin
        miscompares++;
        $display("FAIL wrap_beat%0d: addr=%0d data=%h last=%b, required addr=%0d data=%h last=%b",
                 i, got_addr[i], got_data[i], got_last[i], ea[i], ed[i], (i == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    int nb = 0, nd = 0, stall_left = 5;
    logic [4:0]  ref_addr;
    logic [31:0] ref_data;
    logic        ref_last;
    @(negedge clk);
    first_reg = 5'd8; last_reg = 5'd14; start = 1'b1; dump_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 90; c++) begin
      start = 1'b0;
      if (dump_valid && nb == 1 && stall_left > 0) begin
        if (stall_left == 5) begin
          ref_addr = dump_addr; ref_data = dump_data; ref_last = dump_last;
        end else begin
          vectors++;
          if (dump_addr !== ref_addr || dump_data !== ref_data || dump_last !== ref_last) begin
            miscompares++;
            $display("FAIL bp_hold: addr=%0d data=%h last=%b, required %0d %h %b",
                     dump_addr, dump_data, dump_last, ref_addr, ref_data, ref_last);
          end
        end
        if (stall_left == 3) begin
          // CPU write to the captured entry plus a stray start while busy.
          rf[9] = 32'h5555_5555; first_reg = 5'd0; last_reg = 5'd0; start = 1'b1;
        end
        dump_ready = 1'b0;
        stall_left--;
      end else begin
        dump_ready = 1'b1;
        if (dump_valid) begin
          vectors++;
          if (dump_addr !== 5'(8 + nb)) begin
            miscompares++;
            $display("FAIL bp_addr%0d: got %0d, required %0d", nb, dump_addr, 8 + nb);
          end
          if (nb == 1) begin
            vectors++;
            if (dump_data !== 32'h1) begin
              miscompares++;
              $display("FAIL bp_captured: got %h, required 00000001", dump_data);
            end
          end
          nb++;
        end
      end
      if (done) nd++;
      @(negedge clk);
    end
    rf[9] = 32'h1;
    dump_ready = 1'b1;
    vectors++;
    if (nb !== 7 || nd !== 1) begin
      miscompares++;
      $display("FAIL bp_count: beats=%0d done=%0d, required 7 1", nb, nd);
    end
  endtask

  task automatic test_reset_mid();
    int nb = 0, nd = 0;
    bit hit = 0;
    @(negedge clk);
    first_reg = 5'd8; last_reg = 5'd14; start = 1'b1; dump_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (dump_valid) begin
        if (nb == 2) begin
          dump_ready = 1'b0; reset = 1'b1; hit = 1;
        end else begin
          nb++;
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (!hit) begin miscompares++; $display("FAIL rm_reach: third beat never seen, required seen"); end
    vectors++;
    if ({rf_raddr, dump_addr, dump_data, dump_valid, dump_last, busy, done} !== 44'd0) begin
      miscompares++;
      $display("FAIL rm_outputs: raddr=%h addr=%h data=%h valid=%b last=%b busy=%b done=%b, required all 0",
               rf_raddr, dump_addr, dump_data, dump_valid, dump_last, busy, done);
    end
    reset = 1'b0; dump_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || dump_valid) nd++;
    end
    vectors++;
    if (nd !== 0) begin miscompares++; $display("FAIL rm_no_done: activity %0d, required 0", nd); end
    run_dump(5'd20, 5'd21);
    vectors++;
    if (nbeats !== 2 || ndone !== 1 || got_addr[0] !== 5'd20 || got_data[0] !== 32'h2020_0020) begin
      miscompares++;
      $display("FAIL rm_restart: beats=%0d done=%0d addr=%0d data=%h, required 2 1 20 20200020",
               nbeats, ndone, got_addr[0], got_data[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    // Results the CPU's ALU program leaves behind.
    rf[8]  = 32'h1;        rf[9]  = 32'h1;        rf[10] = 32'h7;
    rf[11] = 32'hfffffffb; rf[12] = 32'h3;        rf[13] = 32'hfffffff2;
    rf[14] = 32'hfffffff7;
    rf[1]  = 32'h0000_0011; rf[20] = 32'h2020_0020; rf[21] = 32'h2121_0021;
    rf[30] = 32'h3030_0030; rf[31] = 32'hdead_beef;
    reset = 1'b0; start = 1'b0; first_reg = '0; last_reg = '0; dump_ready = 1'b1;
    test_reset();
    test_alu_dump();
    test_single();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
